// File: rtl/fp32_adder.sv
// rtl/fp32_adder.sv - IEEE-754 binary32 adder, round-to-nearest-even
// Multi-cycle FSM with stb/ack handshakes on A, B and Z.
module fp32_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1,
    NORM1, NORM2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_MIN  = -10'sd126;
  localparam logic signed [9:0] E_ZERO = -10'sd127;
  localparam logic signed [9:0] E_MAX  = 10'sd127;
  localparam logic signed [9:0] E_INF  = 10'sd128;
  localparam logic signed [9:0] BIAS   = 10'sd127;

  state_t             state;
  logic [31:0]        a, b;
  logic [26:0]        a_m, b_m;
  logic [23:0]        z_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic               guard, round_bit, sticky;
  logic [27:0]        sum;

  logic signed [9:0]  e_diff;
  logic [7:0]         z_biased;
  logic               a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;

  assign e_diff   = a_e - b_e;
  assign z_biased = z_e[7:0] + 8'd127;
  assign a_inf    = (a_e == E_INF);
  assign b_inf    = (b_e == E_INF);
  assign a_nan    = a_inf && (|a_m);
  assign b_nan    = b_inf && (|b_m);
  assign a_zero   = (a_e == E_ZERO) && !(|a_m);
  assign b_zero   = (b_e == E_ZERO) && !(|b_m);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z     <= 32'd0;
      output_z_stb <= 1'b0;
      a            <= 32'd0;
      b            <= 32'd0;
      a_m          <= 27'd0;
      b_m          <= 27'd0;
      z_m          <= 24'd0;
      a_e          <= 10'sd0;
      b_e          <= 10'sd0;
      z_e          <= 10'sd0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      sum          <= 28'd0;
    end else begin
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= GET_B;
          end
        end
        GET_B: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          a_m   <= {1'b0, a[22:0], 3'd0};
          b_m   <= {1'b0, b[22:0], 3'd0};
          a_e   <= $signed({2'b00, a[30:23]}) - BIAS;
          b_e   <= $signed({2'b00, b[30:23]}) - BIAS;
          a_s   <= a[31];
          b_s   <= b[31];
          state <= SPECIAL;
        end
        SPECIAL: begin
          state        <= PUT_Z;
          output_z_stb <= 1'b1;
          if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s)))
            output_z <= 32'h7FC00000;
          else if (a_inf)
            output_z <= {a_s, 8'hFF, 23'd0};
          else if (b_inf)
            output_z <= {b_s, 8'hFF, 23'd0};
          else if (a_zero && b_zero)
            output_z <= {a_s & b_s, 31'd0};
          else if (a_zero)
            output_z <= b;
          else if (b_zero)
            output_z <= a;
          else begin
            // Subnormals keep a zero hidden bit but use the minimum exponent.
            output_z_stb <= 1'b0;
            state        <= ALIGN;
            if (a_e == E_ZERO) a_e <= E_MIN;
            else               a_m[26] <= 1'b1;
            if (b_e == E_ZERO) b_e <= E_MIN;
            else               b_m[26] <= 1'b1;
          end
        end
        ALIGN: begin
          // Beyond 25 steps only the sticky bit survives, so finish in one go.
          if (a_e == b_e)
            state <= ADD0;
          else if (e_diff > 10'sd25) begin
            b_e <= a_e;
            b_m <= {26'd0, |b_m};
          end else if (e_diff > 10'sd0) begin
            b_e <= b_e + 10'sd1;
            b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
          end else if (e_diff < -10'sd25) begin
            a_e <= b_e;
            a_m <= {26'd0, |a_m};
          end else begin
            a_e <= a_e + 10'sd1;
            a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
          end
        end
        ADD0: begin
          z_e   <= a_e;
          state <= ADD1;
          if (a_s == b_s) begin
            sum <= {1'b0, a_m} + {1'b0, b_m};
            z_s <= a_s;
          end else if (a_m > b_m) begin
            sum <= {1'b0, a_m - b_m};
            z_s <= a_s;
          end else if (a_m < b_m) begin
            sum <= {1'b0, b_m - a_m};
            z_s <= b_s;
          end else begin
            sum <= 28'd0;
            z_s <= 1'b0;
          end
        end
        ADD1: begin
          state <= NORM1;
          if (sum[27]) begin
            z_m       <= sum[27:4];
            guard     <= sum[3];
            round_bit <= sum[2];
            sticky    <= sum[1] | sum[0];
            z_e       <= z_e + 10'sd1;
          end else begin
            z_m       <= sum[26:3];
            guard     <= sum[2];
            round_bit <= sum[1];
            sticky    <= sum[0];
          end
        end
        NORM1: begin
          // An exactly zero sum skips straight to the minimum exponent.
          if ({z_m, guard, round_bit, sticky} == 27'd0) begin
            z_e   <= E_MIN;
            state <= NORM2;
          end else if (!z_m[23] && (z_e > E_MIN)) begin
            z_e       <= z_e - 10'sd1;
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
          end else
            state <= NORM2;
        end
        NORM2: begin
          if (z_e < E_MIN) begin
            z_e       <= z_e + 10'sd1;
            z_m       <= {1'b0, z_m[23:1]};
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end else
            state <= ROUND;
        end
        ROUND: begin
          state <= PACK;
          if (guard && (round_bit || sticky || z_m[0])) begin
            if (&z_m) begin
              z_m <= 24'h800000;
              z_e <= z_e + 10'sd1;
            end else
              z_m <= z_m + 24'd1;
          end
        end
        PACK: begin
          state        <= PUT_Z;
          output_z_stb <= 1'b1;
          if (z_e > E_MAX)
            output_z <= {z_s, 8'hFF, 23'd0};
          else if ((z_e == E_MIN) && !z_m[23])
            output_z <= {z_s, 8'd0, z_m[22:0]};
          else
            output_z <= {z_s, z_biased, z_m[22:0]};
        end
        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// tb/tb_fp32_adder.sv - scoreboard bench for fp32_adder
// Drives A/B with random gaps and a random Z ack delay; expected sums are queued at drive time.
module tb_fp32_adder;

  localparam int NV = 18;
  localparam logic [31:0] VA [NV] = '{
    32'h2D764A65, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000001,
    32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h3F800000,
    32'h3F800000, 32'h3F800001, 32'h40400000, 32'h3F800000, 32'h00800000, 32'hC0000000};
  localparam logic [31:0] VB [NV] = '{
    32'h2C6C33DA, 32'h3F800000, 32'hBF800000, 32'hFF800000, 32'h7F7FFFFF, 32'h00000001,
    32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'hC0400000, 32'h33800000,
    32'h00000001, 32'h33800000, 32'hBF800000, 32'hBF7FFFFF, 32'h80000001, 32'hC0000000};
  localparam logic [31:0] VZ [NV] = '{
    32'h2D98ABAE, 32'h40000000, 32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00000002,
    32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000, 32'hC0400000, 32'h3F800000,
    32'h3F800000, 32'h3F800002, 32'h40000000, 32'h33800000, 32'h007FFFFF, 32'hC0800000};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb, output_z_ack;
  logic        input_a_ack, input_b_ack, output_z_stb;
  logic [31:0] output_z;

  int          checks = 0;
  int          errors = 0;
  int          a_xfers = 0, b_xfers = 0, z_xfers = 0, z_idx = 0;
  logic [31:0] sb [$];
  logic        hold_valid = 1'b0;
  logic [31:0] hold_val = 32'd0;

  fp32_adder dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs only change 1 time unit after a rising edge, so the falling edge sees what the next edge will.
  always @(negedge clk) begin
    if (rst) begin
      if (hold_valid) begin
        check("z_stb_held", 32'(output_z_stb), 32'd1);
        check("z_stable", output_z, hold_val);
      end
      check("ack_excl", 32'(input_a_ack & input_b_ack), 32'd0);
      if (input_a_stb && input_a_ack) a_xfers++;
      if (input_b_stb && input_b_ack) b_xfers++;
      if (output_z_stb && output_z_ack) z_xfers++;
      hold_valid = output_z_stb && !output_z_ack;
      hold_val   = output_z;
    end else
      hold_valid = 1'b0;
  end

  task automatic send_a(input logic [31:0] v);
    int n = 0;
    input_a = v;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 300) begin tick(); n++; end
    if (!input_a_ack) check("a_timeout", 32'(input_a_ack), 32'd1);
    else tick();
    input_a_stb = 1'b0;
    input_a = $urandom;
  endtask

  task automatic send_b(input logic [31:0] v);
    int n = 0;
    input_b = v;
    input_b_stb = 1'b1;
    while (!input_b_ack && n < 300) begin tick(); n++; end
    if (!input_b_ack) check("b_timeout", 32'(input_b_ack), 32'd1);
    else tick();
    input_b_stb = 1'b0;
    input_b = $urandom;
  endtask

  task automatic receive();
    int n = 0;
    logic [31:0] got, exp;
    while (!output_z_stb && n < 300) begin tick(); n++; end
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
    if (!output_z_stb) check("z_timeout", 32'(output_z_stb), 32'd1);
    else begin
      got = output_z;
      repeat ($urandom_range(0, 3)) tick();
      output_z_ack = 1'b1;
      tick();
      output_z_ack = 1'b0;
      check("z_stb_drop", 32'(output_z_stb), 32'd0);
      check($sformatf("z[%0d]", z_idx), got, exp);
      check($sformatf("z_hold[%0d]", z_idx), output_z, exp);
    end
    z_idx++;
  endtask

  task automatic run_driver();
    for (int i = 0; i < NV; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      sb.push_back(VZ[i]);
      fork
        send_a(VA[i]);
        send_b(VB[i]);
      join
    end
  endtask

  task automatic run_consumer();
    for (int i = 0; i < NV; i++) receive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    input_a = 32'd0;
    input_b = 32'd0;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) tick();
    check("rst_a_ack", 32'(input_a_ack), 32'd0);
    check("rst_b_ack", 32'(input_b_ack), 32'd0);
    check("rst_z_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b1;
    tick();
    check("rel_a_ack", 32'(input_a_ack), 32'd1);
    check("rel_b_ack", 32'(input_b_ack), 32'd0);

    fork
      run_driver();
      run_consumer();
    join

    // Abandon an operation while it is still aligning a 24-step exponent gap.
    fork
      send_a(32'h3F800000);
      send_b(32'h33800000);
    join
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    check("mid_a_ack", 32'(input_a_ack), 32'd0);
    check("mid_b_ack", 32'(input_b_ack), 32'd0);
    check("mid_z_stb", 32'(output_z_stb), 32'd0);
    check("mid_z", output_z, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rel_a_ack", 32'(input_a_ack), 32'd1);
    sb.push_back(32'h40000000);
    fork
      send_a(32'h3F800000);
      send_b(32'h3F800000);
    join
    receive();

    repeat (2) tick();
    check("a_xfers", 32'(a_xfers), 32'(NV + 2));
    check("b_xfers", 32'(b_xfers), 32'(NV + 2));
    check("z_xfers", 32'(z_xfers), 32'(NV + 1));
    check("sb_left", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
- IEEE-754 single-precision floating-point adder.
- Multi-cycle state machine with independent stb/ack handshakes on operands A and B and on result Z.
- Used as a streaming arithmetic unit between handshake-based producer and consumer blocks. Computes Z = A + B with round-to-nearest-even.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- input_a  input  32  operand A, IEEE-754 binary32
- input_a_stb  input  1  A valid
- input_a_ack  output  1  A accepted / ready
- input_b  input  32  operand B, IEEE-754 binary32
- input_b_stb  input  1  B valid
- input_b_ack  output  1  B accepted / ready
- output_z  output  32  result, binary32
- output_z_stb  output  1  result valid
- output_z_ack  input  1  consumer accepted result

Behaviour:
- Reset (rst low, asynchronous):
  - state=GET_A; input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
  - Internal registers cleared. Reset mid-operation abandons the current sum.
  - After release, the FSM re-enters GET_A on the next edge.
- Handshake rule:
  - A transfer occurs on a rising edge where stb=1 and ack=1.
  - After a transfer, ack/stb deasserts on that same edge.
  - stb without ack (or ack without stb) causes no transfer. Inputs are sampled only at the transfer edge.
- FSM states, one per cycle unless noted:
  - GET_A: input_a_ack=1; on A transfer latch A, go GET_B.
  - GET_B: input_b_ack=1; on B transfer latch B, go UNPACK. B is never accepted before A.
  - UNPACK: split sign, exponent (unbiased, exp-127), 23-bit mantissa of each operand.
  - SPECIAL:
    - Either NaN -> Z=0x7FC00000.
    - inf + inf of opposite sign -> 0x7FC00000.
    - inf + x -> that inf.
    - Both zero -> +0, or -0 only when both are -0.
    - One zero -> other operand unchanged.
    - All of these go to PUT_Z.
    - Otherwise insert hidden bit (0 for subnormal, exponent forced to -126) and go ALIGN.
  - ALIGN:
    - Shift the smaller-exponent mantissa right by 1 per cycle until exponents match.
    - Bits shifted out OR into a sticky bit.
    - Significands carry 3 extra LSBs (guard, round, sticky): 27-bit working width.
  - ADD0:
    - Same signs: add magnitudes.
    - Different signs: subtract smaller from larger; result sign = sign of larger magnitude.
    - Exact cancellation gives +0.
  - ADD1:
    - Carry out (28th bit): shift right 1, exponent+1, preserve sticky.
    - Extract 24-bit mantissa plus guard, round, sticky.
  - NORM1: while mantissa[23]=0 and exp>-126, shift left 1 (guard shifts in), exp-1; one step per cycle.
  - NORM2: while exp<-126, shift right 1, exp+1, update guard/round/sticky.
  - ROUND:
    - Round-to-nearest-even: increment when guard & (round|sticky|mantissa[0]).
    - Mantissa overflow to 2^24 -> exponent+1.
  - PACK:
    - Biased exponent = exp+127.
    - Exponent -126 with mantissa[23]=0 -> biased exponent 0 (subnormal).
    - exp>127 -> +/-inf (0x7F800000 | sign).
  - PUT_Z: output_z_stb=1, output_z stable; on output_z_ack=1 at an edge, stb drops and the FSM goes to GET_A.
- Latency:
  - Variable; depends on exponent difference and normalisation shifts.
  - Bounded by about 60 cycles from B transfer to Z valid.
  - No pipelining: one operation in flight at a time.
- output_z holds its last value after the handshake until the next PUT_Z.

Test Plan:
- Reset behaviour: hold rst low, toggle clk -> all acks and stb 0, output_z 0. Release -> input_a_ack=1 next cycle.
- A=0x2D764A65, B=0x2C6C33DA, stb held until acked, output_z_ack=1 when stb seen -> output_z=0x2D98ABAE. Covers align by 2, carry-out renormalise, round-up.
- A=0x3F800000 (1.0), B=0x3F800000 -> 0x40000000. A=0x3F800000, B=0xBF800000 -> 0x00000000.
- Special values:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x00000001 + 0x00000001 -> 0x00000002 (subnormal).
- Handshake stress:
  - Toggle input_a_stb/input_b_stb every 5 ns and delay output_z_ack several cycles -> only single transfers occur.
  - output_z_stb stays high with stable data until acked.
- Reset mid-operation: assert rst during ALIGN -> outputs return to reset values immediately; the next operation computes correctly.
